// File: rtl/oled_spi_responder.sv
// SSD1331-side SPI receiver: resynchronises the OLED link, assembles bytes, decodes
// the column/row window commands and emits addressed pixel writes for a shadow framebuffer.
module oled_spi_responder #(
   parameter int unsigned N            = 8,
   parameter int unsigned NUM_COL      = 96,
   parameter int unsigned NUM_ROW      = 64,
   parameter int unsigned N_COLOR_BITS = 8,
   localparam int unsigned CW          = $clog2(NUM_COL),
   localparam int unsigned RW          = $clog2(NUM_ROW)
) (
   input  logic                    i_CLK,
   input  logic                    i_RST,
   input  logic                    i_CS,
   input  logic                    i_SCK,
   input  logic                    i_MOSI,
   input  logic                    i_DC,
   input  logic                    i_RES,
   output logic                    o_BYTE_VALID,
   output logic [N-1:0]            o_BYTE,
   output logic                    o_BYTE_IS_DATA,
   output logic                    o_CMD_VALID,
   output logic [N-1:0]            o_CMD,
   output logic                    o_PIXEL_WE,
   output logic [CW-1:0]           o_PIXEL_COL,
   output logic [RW-1:0]           o_PIXEL_ROW,
   output logic [N_COLOR_BITS-1:0] o_PIXEL_COLOR,
   output logic                    o_ERR
);

   localparam int unsigned BW = $clog2(N);

   localparam logic [2:0] P_CMD   = 3'd0;
   localparam logic [2:0] P_COL_S = 3'd1;
   localparam logic [2:0] P_COL_E = 3'd2;
   localparam logic [2:0] P_ROW_S = 3'd3;
   localparam logic [2:0] P_ROW_E = 3'd4;

   logic [1:0] cs_sync, sck_sync, mosi_sync, dc_sync, res_sync;
   logic       cs_s, sck_s, mosi_s, dc_s;
   logic       cs_d, sck_d, cs_rise_d;
   logic       rst, sck_rise, cs_rise, shift_en, last_bit;

   logic [N-2:0]    shreg;
   logic [BW-1:0]   bit_cnt;
   logic [2:0]      state;
   logic [N-1:0]    arg_start;
   logic [N-1:0]    color_hi;
   logic            phase;
   logic [CW-1:0]   col_start, col_end, col_ptr;
   logic [RW-1:0]   row_start, row_end, row_ptr;

   logic is_cmd, is_data, col_ok, row_ok;
   logic frame_err, win_err, arg_err, pix_done;

   // RES is synchronised here but only i_RST clears the synchronisers, so a held RES keeps the block in reset.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         cs_sync   <= '1;
         sck_sync  <= '0;
         mosi_sync <= '0;
         dc_sync   <= '0;
         res_sync  <= '1;
      end else begin
         cs_sync   <= {cs_sync[0], i_CS};
         sck_sync  <= {sck_sync[0], i_SCK};
         mosi_sync <= {mosi_sync[0], i_MOSI};
         dc_sync   <= {dc_sync[0], i_DC};
         res_sync  <= {res_sync[0], i_RES};
      end
   end

   assign cs_s   = cs_sync[1];
   assign sck_s  = sck_sync[1];
   assign mosi_s = mosi_sync[1];
   assign dc_s   = dc_sync[1];
   assign rst    = i_RST | ~res_sync[1];

   always_comb begin
      sck_rise  = sck_s & ~sck_d;
      cs_rise   = cs_s & ~cs_d;
      // Gating on the previous CS lets a byte finishing on the CS-rise cycle still complete.
      shift_en  = sck_rise & ~cs_d;
      last_bit  = shift_en && (bit_cnt == BW'(N - 1));
      frame_err = cs_rise && (bit_cnt != '0) && !last_bit;
      is_cmd    = o_BYTE_VALID && !o_BYTE_IS_DATA;
      is_data   = o_BYTE_VALID && o_BYTE_IS_DATA;
      col_ok    = (arg_start <= o_BYTE) && (32'(o_BYTE) < NUM_COL);
      row_ok    = (arg_start <= o_BYTE) && (32'(o_BYTE) < NUM_ROW);
      win_err   = is_cmd && (((state == P_COL_E) && !col_ok) || ((state == P_ROW_E) && !row_ok));
      arg_err   = is_data && (state != P_CMD);
      pix_done  = (N_COLOR_BITS == N) || phase;
   end

   always_ff @(posedge i_CLK) begin
      if (rst) begin
         cs_d           <= 1'b1;
         sck_d          <= 1'b0;
         cs_rise_d      <= 1'b0;
         shreg          <= '0;
         bit_cnt        <= '0;
         state          <= P_CMD;
         arg_start      <= '0;
         color_hi       <= '0;
         phase          <= 1'b0;
         col_start      <= '0;
         col_end        <= CW'(NUM_COL - 1);
         col_ptr        <= '0;
         row_start      <= '0;
         row_end        <= RW'(NUM_ROW - 1);
         row_ptr        <= '0;
         o_BYTE_VALID   <= 1'b0;
         o_BYTE         <= '0;
         o_BYTE_IS_DATA <= 1'b0;
         o_CMD_VALID    <= 1'b0;
         o_CMD          <= '0;
         o_PIXEL_WE     <= 1'b0;
         o_PIXEL_COL    <= '0;
         o_PIXEL_ROW    <= '0;
         o_PIXEL_COLOR  <= '0;
         o_ERR          <= 1'b0;
      end else begin
         cs_d         <= cs_s;
         sck_d        <= sck_s;
         cs_rise_d    <= cs_rise;
         o_BYTE_VALID <= 1'b0;
         o_CMD_VALID  <= 1'b0;
         o_PIXEL_WE   <= 1'b0;
         o_ERR        <= frame_err | win_err | arg_err;

         if (last_bit) begin
            o_BYTE         <= {shreg, mosi_s};
            o_BYTE_IS_DATA <= dc_s;
            o_BYTE_VALID   <= 1'b1;
            bit_cnt        <= '0;
         end else if (shift_en) begin
            shreg   <= {shreg[N-3:0], mosi_s};
            bit_cnt <= bit_cnt + BW'(1);
         end else if (cs_rise) begin
            bit_cnt <= '0;
         end

         if (is_cmd) begin
            phase <= 1'b0;
            case (state)
               P_CMD: begin
                  if (o_BYTE == N'(8'h15)) begin
                     state <= P_COL_S;
                  end else if (o_BYTE == N'(8'h75)) begin
                     state <= P_ROW_S;
                  end else begin
                     o_CMD_VALID <= 1'b1;
                     o_CMD       <= o_BYTE;
                  end
               end
               P_COL_S: begin
                  arg_start <= o_BYTE;
                  state     <= P_COL_E;
               end
               P_COL_E: begin
                  if (col_ok) begin
                     col_start <= CW'(arg_start);
                     col_end   <= CW'(o_BYTE);
                     col_ptr   <= CW'(arg_start);
                  end
                  state <= P_CMD;
               end
               P_ROW_S: begin
                  arg_start <= o_BYTE;
                  state     <= P_ROW_E;
               end
               P_ROW_E: begin
                  if (row_ok) begin
                     row_start <= RW'(arg_start);
                     row_end   <= RW'(o_BYTE);
                     row_ptr   <= RW'(arg_start);
                  end
                  state <= P_CMD;
               end
               default: state <= P_CMD;
            endcase
         end

         if (is_data) begin
            state <= P_CMD;
            if (pix_done) begin
               o_PIXEL_WE    <= 1'b1;
               o_PIXEL_COL   <= col_ptr;
               o_PIXEL_ROW   <= row_ptr;
               o_PIXEL_COLOR <= N_COLOR_BITS'({color_hi, o_BYTE});
               phase         <= 1'b0;
               if (col_ptr == col_end) begin
                  col_ptr <= col_start;
                  row_ptr <= (row_ptr == row_end) ? row_start : row_ptr + RW'(1);
               end else begin
                  col_ptr <= col_ptr + CW'(1);
               end
            end else begin
               color_hi <= o_BYTE;
               phase    <= 1'b1;
            end
         end

         // Delayed so the final byte of a frame is paired before the phase is dropped.
         if (cs_rise_d) begin
            phase <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_oled_spi_responder.sv
// Directed bench for oled_spi_responder on a 2x2 display: stimulus pushes expected
// events into queues, a negedge monitor pops and compares whatever the DUT emits.
module tb_oled_spi_responder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cs = 1'b1, sck = 1'b0, mosi = 1'b0, dc = 1'b0, res = 1'b1;
   logic       byte_valid, byte_is_data, cmd_valid, pixel_we, err;
   logic [7:0] byte_out, cmd;
   logic       pixel_col, pixel_row;
   logic [7:0] pixel_color;

   int total = 0;
   int bad   = 0;

   logic [31:0] q_byte[$];
   logic [31:0] q_cmd[$];
   logic [31:0] q_pix[$];
   logic [31:0] q_err[$];

   always #5 clk = ~clk;

   oled_spi_responder #(
      .N(8),
      .NUM_COL(2),
      .NUM_ROW(2),
      .N_COLOR_BITS(8)
   ) dut (
      .i_CLK(clk),
      .i_RST(rst),
      .i_CS(cs),
      .i_SCK(sck),
      .i_MOSI(mosi),
      .i_DC(dc),
      .i_RES(res),
      .o_BYTE_VALID(byte_valid),
      .o_BYTE(byte_out),
      .o_BYTE_IS_DATA(byte_is_data),
      .o_CMD_VALID(cmd_valid),
      .o_CMD(cmd),
      .o_PIXEL_WE(pixel_we),
      .o_PIXEL_COL(pixel_col),
      .o_PIXEL_ROW(pixel_row),
      .o_PIXEL_COLOR(pixel_color),
      .o_ERR(err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pix(input int c, input int r, input logic [7:0] color);
      return {22'd0, c[0], r[0], color};
   endfunction

   // Scoreboard monitor
   always @(negedge clk) begin
      if (byte_valid === 1'b1) begin
         if (q_byte.size() == 0) chk("byte_unexpected", {31'd0, byte_valid}, 32'd0);
         else chk("byte", {23'd0, byte_is_data, byte_out}, q_byte.pop_front());
      end
      if (cmd_valid === 1'b1) begin
         if (q_cmd.size() == 0) chk("cmd_unexpected", {31'd0, cmd_valid}, 32'd0);
         else chk("cmd", {24'd0, cmd}, q_cmd.pop_front());
      end
      if (pixel_we === 1'b1) begin
         if (q_pix.size() == 0) chk("pix_unexpected", {31'd0, pixel_we}, 32'd0);
         else chk("pix", {22'd0, pixel_col, pixel_row, pixel_color}, q_pix.pop_front());
      end
      if (err === 1'b1) begin
         if (q_err.size() == 0) chk("err_unexpected", {31'd0, err}, 32'd0);
         else chk("err", {31'd0, err}, q_err.pop_front());
      end
   end

   task automatic sck_bit(input logic b, input logic d);
      mosi = b;
      dc   = d;
      sck  = 1'b0;
      repeat (2) @(negedge clk);
      sck = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_bits(input logic [7:0] val, input int nbits, input logic d);
      if (cs) begin
         cs = 1'b0;
         repeat (2) @(negedge clk);
      end
      for (int i = 0; i < nbits; i++) sck_bit(val[7-i], d);
      sck = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_cmd(input logic [7:0] b, input logic passthru);
      q_byte.push_back({24'd0, b});
      if (passthru) q_cmd.push_back({24'd0, b});
      send_bits(b, 8, 1'b0);
   endtask

   task automatic send_data(input logic [7:0] b);
      q_byte.push_back({23'd0, 1'b1, b});
      send_bits(b, 8, 1'b1);
   endtask

   task automatic raise_cs();
      cs = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset state
      repeat (2) @(negedge clk);
      chk("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
      chk("rst_byte", {24'd0, byte_out}, 32'd0);
      chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
      chk("rst_pixel", {21'd0, pixel_we, pixel_col, pixel_row, pixel_color}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // 2: pass-through command
      send_cmd(8'hAF, 1'b1);
      raise_cs();

      // 3: full-window fill and wrap
      q_pix.push_back(pix(0, 0, 8'h00));
      q_pix.push_back(pix(1, 0, 8'hFF));
      q_pix.push_back(pix(0, 1, 8'h00));
      q_pix.push_back(pix(1, 1, 8'hFF));
      q_pix.push_back(pix(0, 0, 8'h11));
      send_data(8'h00);
      send_data(8'hFF);
      send_data(8'h00);
      send_data(8'hFF);
      send_data(8'h11);
      raise_cs();

      // 4: window commands are consumed, pixels follow the new window
      send_cmd(8'h15, 1'b0);
      send_cmd(8'h01, 1'b0);
      send_cmd(8'h01, 1'b0);
      send_cmd(8'h75, 1'b0);
      send_cmd(8'h00, 1'b0);
      send_cmd(8'h01, 1'b0);
      q_pix.push_back(pix(1, 0, 8'hAA));
      q_pix.push_back(pix(1, 1, 8'hBB));
      send_data(8'hAA);
      send_data(8'hBB);
      raise_cs();

      // 5: truncated frame, then a clean byte
      q_err.push_back(32'd1);
      send_bits(8'hE8, 5, 1'b0);
      raise_cs();
      send_cmd(8'hA5, 1'b1);
      raise_cs();

      // 6: illegal window leaves pointer at (1,0)
      send_cmd(8'h15, 1'b0);
      send_cmd(8'h01, 1'b0);
      q_err.push_back(32'd1);
      send_cmd(8'h00, 1'b0);
      q_pix.push_back(pix(1, 0, 8'h33));
      send_data(8'h33);
      raise_cs();

      // reset mid-byte: nothing emitted
      send_bits(8'hC3, 4, 1'b1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      cs  = 1'b1;
      sck = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // window and pointer back to defaults after reset
      q_pix.push_back(pix(0, 0, 8'h5C));
      send_data(8'h5C);
      raise_cs();
      repeat (10) @(negedge clk);

      chk("byte_pending", q_byte.size(), 32'd0);
      chk("cmd_pending", q_cmd.size(), 32'd0);
      chk("pix_pending", q_pix.size(), 32'd0);
      chk("err_pending", q_err.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
